// File: rtl/dbi_rx_cmd_decoder_pkg.sv
// Shared opcodes, FSM state encoding and panel defaults
// for the DBI receive-side command decoder.
package dbi_rx_cmd_decoder_pkg;

    localparam logic [7:0] OP_SOFT_RST = 8'h01;
    localparam logic [7:0] OP_DISP_ON  = 8'h29;
    localparam logic [7:0] OP_CASET    = 8'h2A;
    localparam logic [7:0] OP_RASET    = 8'h2B;
    localparam logic [7:0] OP_RAMWR    = 8'h2C;
    localparam logic [7:0] OP_MADCTL   = 8'h36;

    localparam int H_RES_DEF = 320;
    localparam int V_RES_DEF = 240;
    localparam int BPP_DEF   = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_WAIT,
        S_COL,
        S_ROW,
        S_ACS,
        S_STM,
        S_DRAIN
    } state_t;

    function automatic logic range_ok(
        input logic [15:0] s,
        input logic [15:0] e,
        input int          res
    );
        return (s <= e) && (int'(e) < res);
    endfunction

endpackage

// File: rtl/dbi_rx_cmd_decoder_if.sv
// Beat stream from the DBI RX PHY plus the frame-buffer
// write port; slave is the decoder, master drives beats.
interface dbi_rx_cmd_decoder_if #(
    parameter int DW = 8,
    parameter int AW = 18
);
    logic          drp_rx_hrst_i;
    logic [DW-1:0] drp_rx_cmd_typ_i;
    logic [DW-1:0] drp_rx_cmd_dat_i;
    logic          drp_rx_last_i;
    logic          drp_rx_no_dat_i;
    logic          drp_rx_vld_i;
    logic          drp_rx_rdy_o;
    logic          fb_wr_rdy_i;
    logic          fb_wr_vld_o;
    logic [AW-1:0] fb_wr_addr_o;
    logic [DW-1:0] fb_wr_dat_o;

    modport master (
        output drp_rx_hrst_i, drp_rx_cmd_typ_i, drp_rx_cmd_dat_i,
        output drp_rx_last_i, drp_rx_no_dat_i, drp_rx_vld_i,
        output fb_wr_rdy_i,
        input  drp_rx_rdy_o, fb_wr_vld_o, fb_wr_addr_o, fb_wr_dat_o
    );

    modport slave (
        input  drp_rx_hrst_i, drp_rx_cmd_typ_i, drp_rx_cmd_dat_i,
        input  drp_rx_last_i, drp_rx_no_dat_i, drp_rx_vld_i,
        input  fb_wr_rdy_i,
        output drp_rx_rdy_o, fb_wr_vld_o, fb_wr_addr_o, fb_wr_dat_o
    );
endinterface

// File: rtl/dbi_rx_win_cursor.sv
// Windowed write cursor: column, row and byte lane inside
// the active window, turned into a frame-buffer byte address.
module dbi_rx_win_cursor #(
    parameter int H_RES = 320,
    parameter int BPP   = 2,
    parameter int FB_AW = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             fresh,
    input  logic             step,
    input  logic [15:0]      s_col,
    input  logic [15:0]      e_col,
    input  logic [15:0]      s_row,
    input  logic [15:0]      e_row,
    output logic [FB_AW-1:0] addr
);
    localparam int BSW = (BPP > 1) ? $clog2(BPP) : 1;
    localparam logic [BSW-1:0]   B_LAST = BSW'(BPP - 1);
    localparam logic [FB_AW-1:0] HR     = FB_AW'(H_RES);
    localparam logic [FB_AW-1:0] BP     = FB_AW'(BPP);

    logic [15:0]    col;
    logic [15:0]    row;
    logic [BSW-1:0] bsel;
    logic [15:0]    ec;
    logic [15:0]    er;
    logic [BSW-1:0] eb;

    // a fresh stream starts at the window origin in the same cycle
    assign ec = fresh ? s_col : col;
    assign er = fresh ? s_row : row;
    assign eb = fresh ? '0 : bsel;

    assign addr = (FB_AW'(er) * HR + FB_AW'(ec)) * BP + FB_AW'(eb);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col  <= '0;
            row  <= '0;
            bsel <= '0;
        end else if (step) begin
            if (eb == B_LAST) begin
                bsel <= '0;
                if (ec == e_col) begin
                    col <= s_col;
                    row <= (er == e_row) ? s_row : er + 16'd1;
                end else begin
                    col <= ec + 16'd1;
                    row <= er;
                end
            end else begin
                bsel <= eb + 1'b1;
                col  <= ec;
                row  <= er;
            end
        end
    end

endmodule

// File: rtl/dbi_rx_cmd_decoder.sv
// DBI command decoder: window/control registers, reset stall
// and RAMWR byte streaming into the frame buffer.
module dbi_rx_cmd_decoder
    import dbi_rx_cmd_decoder_pkg::*;
#(
    parameter int INTERNAL_CLK  = 125000000,
    parameter int DBI_IF_D_W    = 8,
    parameter int H_RES         = H_RES_DEF,
    parameter int V_RES         = V_RES_DEF,
    parameter int BPP           = BPP_DEF,
    parameter int RST_STALL_CYC = INTERNAL_CLK / 200,
    parameter int FB_AW         = $clog2(H_RES * V_RES * BPP)
) (
    input  logic                  clk,
    input  logic                  rst,
    dbi_rx_cmd_decoder_if.slave   bus,
    output logic                  disp_on_o,
    output logic [DBI_IF_D_W-1:0] acs_ctrl_o,
    output logic                  busy_o,
    output logic                  err_o
);
    localparam int SCW = $clog2(RST_STALL_CYC + 1);
    localparam logic [SCW-1:0] STALL_LD = SCW'(RST_STALL_CYC - 1);
    localparam logic [15:0] COL_MAX = 16'(H_RES - 1);
    localparam logic [15:0] ROW_MAX = 16'(V_RES - 1);

    state_t           state;
    state_t           eff;
    logic [SCW-1:0]   stall;
    logic [1:0]       cnt;
    logic [23:0]      sh;
    logic [15:0]      s_col;
    logic [15:0]      e_col;
    logic [15:0]      s_row;
    logic [15:0]      e_row;
    logic             idle_nd;
    logic             wr;
    logic             rdy;
    logic             acc;
    logic             clr;
    logic             step;
    logic [15:0]      p_s;
    logic [15:0]      p_e;
    logic             p_ok;
    logic [FB_AW-1:0] cur_addr;

    // IDLE treats the opcode beat as the first beat of its command
    always_comb begin
        eff = state;
        if (state == S_IDLE) begin
            unique case (1'b1)
                bus.drp_rx_cmd_typ_i == OP_CASET:  eff = S_COL;
                bus.drp_rx_cmd_typ_i == OP_RASET:  eff = S_ROW;
                bus.drp_rx_cmd_typ_i == OP_MADCTL: eff = S_ACS;
                bus.drp_rx_cmd_typ_i == OP_RAMWR:  eff = S_STM;
                default:                           eff = S_IDLE;
            endcase
        end
    end

    assign idle_nd = (state == S_IDLE) && bus.drp_rx_no_dat_i;

    // hard-reset beats never reach the frame buffer
    assign wr = !rst && bus.drp_rx_vld_i && !bus.drp_rx_hrst_i
                && (eff == S_STM) && !idle_nd;

    always_comb begin
        rdy = 1'b0;
        if (!rst) begin
            if (wr) rdy = bus.fb_wr_rdy_i;
            else    rdy = (state != S_RST_WAIT);
        end
    end

    assign acc  = bus.drp_rx_vld_i && rdy;
    assign step = acc && wr;
    assign clr  = acc && (bus.drp_rx_hrst_i
                  || ((state == S_IDLE)
                      && (bus.drp_rx_cmd_typ_i == OP_SOFT_RST)));

    assign p_s  = sh[23:8];
    assign p_e  = {sh[7:0], bus.drp_rx_cmd_dat_i};
    assign p_ok = range_ok(p_s, p_e, (eff == S_COL) ? H_RES : V_RES);

    assign bus.drp_rx_rdy_o = rdy;
    assign bus.fb_wr_vld_o  = wr;
    assign bus.fb_wr_addr_o = (eff == S_STM) ? cur_addr : '0;
    assign bus.fb_wr_dat_o  = (eff == S_STM) ? bus.drp_rx_cmd_dat_i : '0;
    assign busy_o           = (state == S_RST_WAIT);

    dbi_rx_win_cursor #(
        .H_RES (H_RES),
        .BPP   (BPP),
        .FB_AW (FB_AW)
    ) u_cursor (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .fresh (state == S_IDLE),
        .step  (step),
        .s_col (s_col),
        .e_col (e_col),
        .s_row (s_row),
        .e_row (e_row),
        .addr  (cur_addr)
    );

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state      <= rst ? S_IDLE : S_RST_WAIT;
            stall      <= rst ? '0 : STALL_LD;
            cnt        <= '0;
            sh         <= '0;
            s_col      <= '0;
            e_col      <= COL_MAX;
            s_row      <= '0;
            e_row      <= ROW_MAX;
            disp_on_o  <= 1'b0;
            acs_ctrl_o <= '0;
            err_o      <= 1'b0;
        end else if (state == S_RST_WAIT) begin
            if (stall == '0) state <= S_IDLE;
            else             stall <= stall - 1'b1;
        end else if (acc) begin
            unique case (eff)
                S_IDLE: begin
                    if (bus.drp_rx_cmd_typ_i == OP_DISP_ON) begin
                        disp_on_o <= 1'b1;
                    end else begin
                        err_o <= 1'b1;
                        if (!bus.drp_rx_last_i) state <= S_DRAIN;
                    end
                end
                S_COL, S_ROW: begin
                    if (idle_nd) begin
                        err_o <= 1'b1;
                    end else if (cnt != 2'd3) begin
                        sh  <= {sh[15:0], bus.drp_rx_cmd_dat_i};
                        cnt <= cnt + 2'd1;
                        state <= eff;
                        if (bus.drp_rx_last_i) begin
                            err_o <= 1'b1;
                            cnt   <= '0;
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= '0;
                        if (!bus.drp_rx_last_i) begin
                            err_o <= 1'b1;
                            state <= S_DRAIN;
                        end else begin
                            state <= S_IDLE;
                            if (!p_ok) begin
                                err_o <= 1'b1;
                            end else if (eff == S_COL) begin
                                s_col <= p_s;
                                e_col <= p_e;
                            end else begin
                                s_row <= p_s;
                                e_row <= p_e;
                            end
                        end
                    end
                end
                S_ACS: begin
                    if (idle_nd) begin
                        err_o <= 1'b1;
                    end else if (bus.drp_rx_last_i) begin
                        acs_ctrl_o <= bus.drp_rx_cmd_dat_i;
                        state      <= S_IDLE;
                    end else begin
                        err_o <= 1'b1;
                        state <= S_DRAIN;
                    end
                end
                S_STM: begin
                    state <= (bus.drp_rx_last_i || idle_nd)
                             ? S_IDLE : S_STM;
                end
                S_DRAIN: begin
                    if (bus.drp_rx_last_i) state <= S_IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule
